// File: rtl/scan_seq_4.sv
// scan_seq_4 - programmable scan sequencer feeding a 4-to-16 one-hot decoder.
//
// Steps a 4-bit select code through 0..15 (up) or 15..0 (down). Each code
// dwells div+1 clock cycles. The sequencer runs either continuously or for
// a single pass, and has start/stop/hold control.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   single-cycle request to begin (or restart) a scan
//   stop   in   single-cycle request to abort a scan (wins over start)
//   hold   in   level; freezes prescaler and code while in RUN
//   mode   in   0 = continuous wrap, 1 = single pass (sampled at start)
//   dir    in   0 = up, 1 = down (sampled at start)
//   div    in   dwell-minus-one, DIV_W bits (sampled at start)
//   A      out  4-bit select code to the decoder
//   valid  out  A carries an active scan code
//   step   out  one-cycle pulse with each new code after the first
//   done   out  one-cycle pulse at the end of a single pass
//   busy   out  sequencer is in RUN
module scan_seq_4 #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic             dir,
  input  logic [DIV_W-1:0] div,
  output logic [3:0]       A,
  output logic             valid,
  output logic             step,
  output logic             done,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] presc, presc_nxt;
  logic [DIV_W-1:0] div_l, div_l_nxt;
  logic             mode_l, mode_l_nxt;
  logic             dir_l, dir_l_nxt;
  logic [3:0]       a_nxt;
  logic             valid_nxt, step_nxt, done_nxt, busy_nxt;
  logic [3:0]       last_code;

  // Terminal code of a single pass depends on the latched direction.
  assign last_code = dir_l ? 4'd0 : 4'd15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      presc  <= '0;
      div_l  <= '0;
      mode_l <= 1'b0;
      dir_l  <= 1'b0;
      A      <= 4'd0;
      valid  <= 1'b0;
      step   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      div_l  <= div_l_nxt;
      mode_l <= mode_l_nxt;
      dir_l  <= dir_l_nxt;
      A      <= a_nxt;
      valid  <= valid_nxt;
      step   <= step_nxt;
      done   <= done_nxt;
      busy   <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    div_l_nxt  = div_l;
    mode_l_nxt = mode_l;
    dir_l_nxt  = dir_l;
    a_nxt      = A;
    valid_nxt  = valid;
    busy_nxt   = busy;
    step_nxt   = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // stop beats start even when the sequencer is idle.
        if (start && !stop) begin
          mode_l_nxt = mode;
          dir_l_nxt  = dir;
          div_l_nxt  = div;
          a_nxt      = dir ? 4'd15 : 4'd0;
          presc_nxt  = '0;
          state_nxt  = RUN;
          valid_nxt  = 1'b1;
          busy_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
        end else if (start) begin
          // Restart: reload as from IDLE, without a step pulse.
          mode_l_nxt = mode;
          dir_l_nxt  = dir;
          div_l_nxt  = div;
          a_nxt      = dir ? 4'd15 : 4'd0;
          presc_nxt  = '0;
        end else if (!hold) begin
          if (presc == div_l) begin
            presc_nxt = '0;
            if (mode_l && (A == last_code)) begin
              // End of a single pass: A keeps the last code.
              state_nxt = IDLE;
              valid_nxt = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              // 4-bit arithmetic gives the 15<->0 wrap for free.
              a_nxt    = dir_l ? (A - 4'd1) : (A + 4'd1);
              step_nxt = 1'b1;
            end
          end else begin
            presc_nxt = presc + DIV_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_seq_4.sv
// Testbench for scan_seq_4: a vector table for the start/stop/hold control
// corners, plus hand-written multi-cycle sequences for pass length, wrap,
// hold dwell, restart and asynchronous reset.
module tb_scan_seq_4;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, hold, mode, dir;
  logic [DIV_W-1:0] div;
  logic [3:0]       A;
  logic             valid, step, done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  scan_seq_4 #(.DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .mode(mode), .dir(dir), .div(div),
    .A(A), .valid(valid), .step(step), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, hold, mode, dir;
    logic [7:0] div;
    logic [3:0] a;
    logic       valid, step, done, busy;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic check_all(input string nm, input int idx, input int ea,
                           input int ev, input int es, input int ed, input int eb);
    check({nm, ".A"},     idx, int'(A),     ea);
    check({nm, ".valid"}, idx, int'(valid), ev);
    check({nm, ".step"},  idx, int'(step),  es);
    check({nm, ".done"},  idx, int'(done),  ed);
    check({nm, ".busy"},  idx, int'(busy),  eb);
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; hold = 0;
  endtask

  task automatic go(input logic m, input logic d, input logic [7:0] dv);
    start = 1; mode = m; dir = d; div = dv;
    tick();
    start = 0;
  endtask

  function automatic vec_t mk(input logic st, sp, h, m, d, input logic [7:0] dv,
                              input logic [3:0] a, input logic v, s, dn, b);
    vec_t r;
    r.start = st; r.stop = sp; r.hold = h; r.mode = m; r.dir = d; r.div = dv;
    r.a = a; r.valid = v; r.step = s; r.done = dn; r.busy = b;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int t, ea, es;
    //             st sp h  m  d  div   A   v  s  d  b
    tbl[0]  = mk(1, 0, 0, 0, 0, 8'd1, 4'd0,  1, 0, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 8'd1, 4'd0,  1, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 8'd1, 4'd1,  1, 1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 8'd1, 4'd1,  1, 0, 0, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 8'd1, 4'd2,  1, 1, 0, 1);
    tbl[5]  = mk(1, 1, 0, 0, 0, 8'd1, 4'd2,  0, 0, 0, 0); // start+stop: stop wins
    tbl[6]  = mk(0, 1, 0, 0, 0, 8'd1, 4'd2,  0, 0, 0, 0); // stop in IDLE
    tbl[7]  = mk(0, 0, 1, 0, 0, 8'd1, 4'd2,  0, 0, 0, 0); // hold in IDLE
    tbl[8]  = mk(1, 0, 0, 0, 1, 8'd0, 4'd15, 1, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 1, 8'd0, 4'd14, 1, 1, 0, 1);
    tbl[10] = mk(1, 0, 0, 1, 0, 8'd0, 4'd0,  1, 0, 0, 1); // restart in RUN
    tbl[11] = mk(0, 0, 0, 1, 0, 8'd0, 4'd1,  1, 1, 0, 1);
    tbl[12] = mk(0, 0, 1, 1, 0, 8'd0, 4'd1,  1, 0, 0, 1);
    tbl[13] = mk(0, 0, 1, 1, 0, 8'd0, 4'd1,  1, 0, 0, 1);
    tbl[14] = mk(0, 0, 0, 1, 0, 8'd0, 4'd2,  1, 1, 0, 1);
    tbl[15] = mk(0, 1, 0, 1, 0, 8'd0, 4'd2,  0, 0, 0, 0);

    rst_n = 0; idle_inputs(); mode = 0; dir = 0; div = '0;
    tick(); tick();
    check_all("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    tick();
    check_all("post_reset", 0, 0, 0, 0, 0, 0);

    // Table-driven control corners.
    for (int i = 0; i < 16; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; hold = tbl[i].hold;
      mode = tbl[i].mode; dir = tbl[i].dir; div = tbl[i].div;
      tick();
      check_all("tbl", i, int'(tbl[i].a), int'(tbl[i].valid), int'(tbl[i].step),
                int'(tbl[i].done), int'(tbl[i].busy));
    end
    idle_inputs();

    // Single pass up, div=0: 16 codes, 15 steps, done after 16 cycles.
    go(1'b1, 1'b0, 8'd0);
    check_all("sp_up", 0, 0, 1, 0, 0, 1);
    for (int k = 1; k < 16; k++) begin
      tick();
      check_all("sp_up", k, k, 1, 1, 0, 1);
    end
    tick();
    check_all("sp_up_done", 16, 15, 0, 0, 1, 0);
    tick();
    check_all("sp_up_after", 17, 15, 0, 0, 0, 0);

    // Continuous down, div=2: 40 codes, wrapping 0 -> 15 with a step.
    go(1'b0, 1'b1, 8'd2);
    check_all("cont_dn", 0, 15, 1, 0, 0, 1);
    for (int c = 1; c < 120; c++) begin
      tick();
      check_all("cont_dn", c, (15 - c / 3) & 15, 1, (c % 3 == 0) ? 1 : 0, 0, 1);
    end
    stop = 1; tick(); stop = 0;
    check_all("cont_dn_stop", 0, (15 - 119 / 3) & 15, 0, 0, 0, 0);

    // Hold for 5 cycles while A=4 in a single pass up with div=1.
    go(1'b1, 1'b0, 8'd1);
    for (int c = 1; c <= 37; c++) begin
      hold = (c >= 9 && c <= 13);
      tick();
      if (c >= 9 && c <= 13) begin
        check_all("hold", c, 4, 1, 0, 0, 1);
      end else begin
        t = (c > 13) ? c - 5 : c;
        if (t == 32) check_all("hold_done", c, 15, 0, 0, 1, 0);
        else         check_all("hold", c, t / 2, 1, (t % 2 == 0) ? 1 : 0, 0, 1);
      end
    end
    hold = 0;

    // Restart in RUN: continuous up div=4, at A=6 restart down with div=0.
    go(1'b0, 1'b0, 8'd4);
    for (int c = 1; c <= 31; c++) tick();
    check_all("rs_pre", 31, 6, 1, 0, 0, 1);
    go(1'b0, 1'b1, 8'd0);
    check_all("rs_reload", 0, 15, 1, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_all("rs_down", k, 15 - k, 1, 1, 0, 1);
    end
    stop = 1; tick(); stop = 0;

    // Asynchronous reset in the middle of a continuous scan at A=7.
    go(1'b0, 1'b0, 8'd3);
    for (int c = 1; c <= 29; c++) tick();
    check_all("rst_pre", 29, 7, 1, 0, 0, 1);
    #2 rst_n = 0;
    #1 check_all("rst_mid", 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_all("rst_after", k, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
